// File: rtl/display_scan_ctrl.sv
// Scan scheduler for an 8-digit seven-segment display: refresh timebase,
// digit select, per-slot blanking and active-low anode drive.
module display_scan_ctrl #(
   parameter int DIV   = 100000,
   parameter int BLANK = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] digit_en,
   output logic [7:0] AN,
   output logic [2:0] seg_sel,
   output logic       slot_start,
   output logic       frame_done
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

   // With no blanking interval a slot begins directly in DRIVE.
   localparam state_t SLOT_ENTRY = (BLANK == 0) ? S_DRIVE : S_BLANK;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [2:0]      seg_q, seg_d;
   logic [7:0]      mask_q, mask_d;
   logic [7:0]      an_q, an_d;
   logic            ss_q, ss_d;
   logic            fd_q, fd_d;

   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      seg_d   = seg_q;
      mask_d  = mask_q;
      ss_d    = 1'b0;
      fd_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            seg_d = 3'd0;
            if (enable) begin
               mask_d  = digit_en;
               ss_d    = 1'b1;
               state_d = SLOT_ENTRY;
            end
         end
         S_BLANK: begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(BLANK))
               state_d = S_DRIVE;
         end
         S_DRIVE: begin
            if (cnt_q == CW'(DIV - 1)) begin
               cnt_d = '0;
               if (seg_q != 3'd7) begin
                  seg_d   = seg_q + 3'd1;
                  ss_d    = 1'b1;
                  state_d = SLOT_ENTRY;
               end else begin
                  fd_d  = 1'b1;
                  seg_d = 3'd0;
                  if (enable) begin
                     mask_d  = digit_en;
                     ss_d    = 1'b1;
                     state_d = SLOT_ENTRY;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Anodes are computed from next-state values so AN stays a pure register.
      an_d = 8'hFF;
      if (state_d == S_DRIVE)
         an_d[seg_d] = ~mask_d[seg_d];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         seg_q   <= 3'd0;
         mask_q  <= 8'h00;
         an_q    <= 8'hFF;
         ss_q    <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         seg_q   <= seg_d;
         mask_q  <= mask_d;
         an_q    <= an_d;
         ss_q    <= ss_d;
         fd_q    <= fd_d;
      end
   end

   assign AN         = an_q;
   assign seg_sel    = seg_q;
   assign slot_start = ss_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: three instances cover the
// blanked, zero-blank and random-mask configurations.
module tb_display_scan_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, en_a, ss_a, fd_a;
   logic [7:0] den_a, an_a;
   logic [2:0] seg_a;
   logic       rst_b, en_b, ss_b, fd_b;
   logic [7:0] den_b, an_b;
   logic [2:0] seg_b;
   logic       rst_c, en_c, ss_c, fd_c;
   logic [7:0] den_c, an_c;
   logic [2:0] seg_c;

   display_scan_ctrl #(.DIV(8), .BLANK(2)) dut_a (
      .clk(clk), .reset(rst_a), .enable(en_a), .digit_en(den_a),
      .AN(an_a), .seg_sel(seg_a), .slot_start(ss_a), .frame_done(fd_a));

   display_scan_ctrl #(.DIV(4), .BLANK(0)) dut_b (
      .clk(clk), .reset(rst_b), .enable(en_b), .digit_en(den_b),
      .AN(an_b), .seg_sel(seg_b), .slot_start(ss_b), .frame_done(fd_b));

   display_scan_ctrl #(.DIV(8), .BLANK(1)) dut_c (
      .clk(clk), .reset(rst_c), .enable(en_c), .digit_en(den_c),
      .AN(an_c), .seg_sel(seg_c), .slot_start(ss_c), .frame_done(fd_c));

   int passed = 0;
   int total  = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      total++;
      assert (observed === expected) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   function automatic logic [12:0] obs(input int which);
      case (which)
         0:       return {an_a, seg_a, ss_a, fd_a};
         1:       return {an_b, seg_b, ss_b, fd_b};
         default: return {an_c, seg_c, ss_c, fd_c};
      endcase
   endfunction

   // Expected outputs at cycle i of a frame, derived from slot/blank timing.
   task automatic check_cycle(input int which, input int div, input int blank,
                              input int i, input logic [7:0] mask, input bit first);
      int          s, c;
      logic [7:0]  ean;
      logic [12:0] o;
      logic        onehot;
      s   = i / div;
      c   = i % div;
      ean = 8'hFF;
      if (c >= blank) ean[s] = ~mask[s];
      o      = obs(which);
      onehot = ($countones(~o[12:5]) <= 1);
      chk($sformatf("d%0d an s%0d c%0d", which, s, c), o[12:5], ean);
      chk($sformatf("d%0d seg s%0d c%0d", which, s, c), {5'b0, o[4:2]}, 8'(s));
      chk($sformatf("d%0d slot_start s%0d c%0d", which, s, c), {7'b0, o[1]}, {7'b0, c == 0});
      chk($sformatf("d%0d frame_done s%0d c%0d", which, s, c), {7'b0, o[0]}, {7'b0, (i == 0) && !first});
      chk($sformatf("d%0d onehot s%0d c%0d", which, s, c), {7'b0, onehot}, 8'd1);
   endtask

   task automatic check_idle(input int which, input string tag, input logic fd_exp);
      logic [12:0] o;
      o = obs(which);
      chk({tag, " an"}, o[12:5], 8'hFF);
      chk({tag, " seg"}, {5'b0, o[4:2]}, 8'd0);
      chk({tag, " slot_start"}, {7'b0, o[1]}, 8'd0);
      chk({tag, " frame_done"}, {7'b0, o[0]}, {7'b0, fd_exp});
   endtask

   initial begin
      logic [7:0] mask, nxt;
      rst_a = 0; rst_b = 0; rst_c = 0;
      en_a = 0; en_b = 0; en_c = 0;
      den_a = 8'hFF; den_b = 8'hFF; den_c = 8'hFF;
      nxt = 8'hFF;
      #2;
      rst_a = 1; rst_b = 1; rst_c = 1;
      #1;
      check_idle(0, "reset", 1'b0);
      tick(); tick();
      check_idle(0, "reset held", 1'b0);
      $display("reset state checked");

      // Basic scan, then mask capture, then enable drop.
      rst_a = 0; en_a = 1;
      tick();
      for (int i = 0; i < 64; i++) begin
         check_cycle(0, 8, 2, i, 8'hFF, 1'b1);
         tick();
      end
      $display("basic scan frame checked");
      for (int i = 0; i < 64; i++) begin
         if (i == 16) den_a = 8'h0F;
         check_cycle(0, 8, 2, i, 8'hFF, 1'b0);
         tick();
      end
      $display("mask change mid-frame checked");
      for (int i = 0; i < 64; i++) begin
         if (i == 24) en_a = 0;
         check_cycle(0, 8, 2, i, 8'h0F, 1'b0);
         tick();
      end
      check_idle(0, "frame end", 1'b1);
      for (int k = 0; k < 10; k++) begin
         tick();
         check_idle(0, $sformatf("idle k%0d", k), 1'b0);
      end
      $display("enable drop checked");

      // Restart, then asynchronous reset in digit 5's drive phase.
      den_a = 8'hFF; en_a = 1;
      tick();
      for (int i = 0; i < 43; i++) begin
         check_cycle(0, 8, 2, i, 8'hFF, 1'b1);
         tick();
      end
      check_cycle(0, 8, 2, 43, 8'hFF, 1'b1);
      #2 rst_a = 1;
      #1 check_idle(0, "async reset", 1'b0);
      en_a = 0;
      tick();
      rst_a = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check_idle(0, $sformatf("post reset k%0d", k), 1'b0);
      end
      $display("restart and async reset checked");

      // Zero blanking interval.
      rst_b = 0; en_b = 1;
      tick();
      for (int i = 0; i < 64; i++) begin
         check_cycle(1, 4, 0, i % 32, 8'hFF, i < 32);
         tick();
      end
      $display("zero blank checked");

      // Random masks, one new mask per frame.
      rst_c = 0; en_c = 1;
      den_c = 8'($urandom);
      mask = den_c;
      tick();
      for (int f = 0; f < 10; f++) begin
         for (int i = 0; i < 64; i++) begin
            if (i == 37) begin
               nxt   = 8'($urandom);
               den_c = nxt;
            end
            check_cycle(2, 8, 1, i, mask, f == 0);
            tick();
         end
         $display("random frame %0d mask %h checked", f, mask);
         mask = nxt;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan scheduler for the 8-digit seven-segment display. It owns the refresh timebase, sequences the digit select driving the 8-to-1 segment mux, and drives the active-low anodes. It inserts a programmable blanking interval at the start of every digit slot to suppress ghosting. It applies a per-digit enable mask, captured once per frame. It sits between the system clock and the display datapath and replaces any free-running per-digit sequencer.

## Interface
- `DIV`, default 100000: clock cycles per digit slot. Legal when `DIV >= 2` and `DIV > BLANK`.
- `BLANK`, default 1000: cycles at the start of each slot with all anodes off. 0 is legal.
- `clk`  in  1: system clock. All state changes on the rising edge.
- `reset`  in  1: reset, asynchronous, active-high.
- `enable`  in  1: scan request. Sampled in IDLE and at every frame end.
- `digit_en`  in  8: per-digit enable mask. Bit i gates anode i. Captured only at frame start.
- `AN`  out  8: anode drive, active-low, registered.
- `seg_sel`  out  3: current digit index to the segment mux, registered.
- `slot_start`  out  1: one-cycle pulse in the first cycle of every slot.
- `frame_done`  out  1: one-cycle pulse after the last cycle of digit 7's slot.

## Operation
- State machine has three states: IDLE, BLANK, DRIVE. Internal registers:
  - slot counter `cnt`, width clog2(DIV), running 0..DIV-1 across each slot;
  - shadow mask `mask_q` (8 bits).
- Reset values:
  - state IDLE;
  - `AN` = 8'hFF, `seg_sel` = 0;
  - `cnt` = 0, `mask_q` = 8'h00;
  - `slot_start` = 0, `frame_done` = 0.
- IDLE:
  - `AN` = 8'hFF, `seg_sel` = 0.
  - On an edge with `enable` = 1: `mask_q` <= `digit_en`, `cnt` <= 0, `seg_sel` <= 0, `slot_start` <= 1.
  - Next state is BLANK, or DRIVE if `BLANK` = 0.
- BLANK:
  - `AN` = 8'hFF. `seg_sel` already holds the upcoming digit, so the mux settles before the anode turns on.
  - `cnt` increments each cycle. Move to DRIVE on the edge where `cnt` becomes `BLANK`.
- DRIVE:
  - `AN[seg_sel]` = ~`mask_q[seg_sel]`. All other bits are 1.
  - At most one anode is low at any time.
  - A masked digit still consumes its full slot with all anodes off, so brightness of the enabled digits is independent of the mask.
- Slot end, i.e. DRIVE with `cnt` = DIV-1:
  - `cnt` <= 0.
  - If `seg_sel` < 7: `seg_sel` <= `seg_sel`+1, `slot_start` <= 1, and go to BLANK (or DRIVE if `BLANK` = 0).
  - If `seg_sel` = 7: `frame_done` <= 1 and `seg_sel` <= 0.
    - If `enable` = 1: reload `mask_q` <= `digit_en`, `slot_start` <= 1, start the next frame.
    - Otherwise go to IDLE.
- `enable` deasserted mid-frame: the frame completes through digit 7, then the block enters IDLE. A frame is never truncated.
- `digit_en` changes mid-frame have no effect until the next frame start.
- Async reset mid-operation forces all reset values immediately, with no further pulses. Scanning resumes from digit 0 only after reset is released and `enable` = 1 is sampled.

## Timing
- All outputs are registered and change only on clock edges or on reset assertion. No combinational path from inputs to outputs.
- Enable-to-display latency: `enable` sampled at edge t0.
  - `slot_start` = 1 and `seg_sel` = 0 in the cycle after t0.
  - First anode low `BLANK` cycles later.
- Slot length is exactly `DIV` cycles: `BLANK` cycles blanked plus `DIV-BLANK` cycles driven.
- Frame length is exactly 8×`DIV` cycles. Back-to-back frames have no gap.
- `frame_done` and the next frame's `slot_start` coincide in the same cycle.
- Pulses are high for exactly one cycle.

## Test plan
- Basic scan (DIV=8, BLANK=2, `digit_en`=8'hFF, `enable` held high):
  - `AN` repeats FF,FF,FE×6, FF,FF,FD×6, … through 7F×6.
  - `seg_sel` steps 0..7 every 8 cycles.
  - `frame_done` pulses every 64 cycles.
  - `slot_start` pulses every 8 cycles.
- Mask capture (DIV=8, BLANK=2): set `digit_en`=8'h0F during digit 2's slot.
  - Digits 4–7 still light in the current frame.
  - The next frame shows `AN`=FF in slots 4–7, with slot timing unchanged (64-cycle frame).
- Enable drop: deassert `enable` during digit 3.
  - Scanning continues to the end of digit 7, `frame_done` pulses once, then `AN`=FF and `seg_sel`=0 held.
  - Reasserting `enable` restarts at digit 0 with `slot_start` the next cycle.
- Async reset: assert `reset` mid-DRIVE on digit 5 with no clock edge.
  - `AN`=FF, `seg_sel`=0, pulses 0 immediately.
  - After release with `enable` low, all outputs stay idle.
- Zero blank (DIV=4, BLANK=0, `digit_en`=8'hFF):
  - `AN` is never FF between digits: FE×4, FD×4, … 7F×4.
  - `frame_done` every 32 cycles.
- One-hot check: over 10 random-mask frames (DIV=8, BLANK=1), no cycle has more than one zero in `AN`.
